// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the RX link supervisor.
//   rx_state_e     : supervisor state, encoded as the frsync_ctrl value driven to the PHY
//   ThrStepDefault : default threshold decrement per search timeout
//   ThrMinDefault  : default lower bound of the correlator threshold
//   TimeoutW       : width of the timeout budget and cycle timer
//   thr_step_down  : clamped threshold decrement helper
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSearch = 2'b01,
    StTrack  = 2'b10,
    StLocked = 2'b11
  } rx_state_e;

  localparam logic [23:0] ThrStepDefault = 24'h000400;
  localparam logic [23:0] ThrMinDefault  = 24'h001000;
  localparam int unsigned TimeoutW       = 20;

  // 25-bit subtraction so an underflow shows up in the borrow bit before clamping.
  function automatic logic [23:0] thr_step_down(input logic [23:0] thr,
                                                input logic [23:0] step,
                                                input logic [23:0] thr_min);
    logic [24:0] diff;
    diff = {1'b0, thr} - {1'b0, step};
    if (diff[24] || (diff[23:0] < thr_min)) begin
      return thr_min;
    end
    return diff[23:0];
  endfunction

endpackage

// File: rtl/rx_frame_window.sv
// LOCKED-state frame/error window.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   active_i   : supervisor is in LOCKED; counters are held at zero otherwise
//   frame_i    : a frame verdict (ok or err) arrived this cycle
//   err_i      : the verdict is a CRC failure
//   err_trip_o : this error brings the window's error count to ERR_THR
module rx_frame_window #(
  parameter int unsigned WIN     = 64,
  parameter int unsigned ERR_THR = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic frame_i,
  input  logic err_i,
  output logic err_trip_o
);

  localparam int unsigned FrmW = $clog2(WIN + 1);
  localparam int unsigned ErrW = $clog2(ERR_THR + 1);

  logic [FrmW-1:0] frame_cnt_q;
  logic [ErrW-1:0] err_cnt_q;
  logic            win_end;

  assign err_trip_o = active_i & frame_i & err_i & (err_cnt_q == ErrW'(ERR_THR - 1));
  assign win_end    = (frame_cnt_q == FrmW'(WIN - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (!active_i || (frame_i && (err_trip_o || win_end))) begin
      // The trip check comes first, so a trip on the window's last frame still drops lock.
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (frame_i) begin
      frame_cnt_q <= frame_cnt_q + FrmW'(1);
      if (err_i) begin
        err_cnt_q <= err_cnt_q + ErrW'(1);
      end
    end
  end

endmodule

// File: rtl/rx_link_ctrl.sv
// RX acquisition/tracking supervisor: sequences frame-sync mode and correlator threshold.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : receiver enable; low forces IDLE
//   thr_init        : starting threshold, sampled on IDLE->SEARCH
//   timeout         : cycle budget for search and frame starvation (0 acts as 1)
//   corr_pr_detect  : preamble-detect pulse
//   frame_ok/err    : CRC verdict pulses
//   thr_lvl         : threshold to PHY
//   frsync_ctrl     : 00 IDLE, 01 SEARCH, 10 TRACK, 11 LOCKED
//   resync          : one-cycle pulse on each fallback to SEARCH from TRACK/LOCKED
//   link_up         : high in LOCKED
//   n_resync        : saturating resync count
module rx_link_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter logic [23:0] THR_STEP = ThrStepDefault,
  parameter logic [23:0] THR_MIN  = ThrMinDefault,
  parameter int unsigned N_LOCK   = 4,
  parameter int unsigned WIN      = 64,
  parameter int unsigned ERR_THR  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [23:0]         thr_init,
  input  logic [TimeoutW-1:0] timeout,
  input  logic                corr_pr_detect,
  input  logic                frame_ok,
  input  logic                frame_err,
  output logic [23:0]         thr_lvl,
  output logic [1:0]          frsync_ctrl,
  output logic                resync,
  output logic                link_up,
  output logic [15:0]         n_resync
);

  localparam int unsigned GoodW = $clog2(N_LOCK + 1);

  rx_state_e           state_q;
  logic [TimeoutW-1:0] timer_q;
  logic [TimeoutW-1:0] timeout_eff;
  logic [23:0]         thr_base_q;
  logic [GoodW-1:0]    good_q;
  logic                timer_hit;
  logic                frame_any;
  logic                err_trip;
  logic                lose_track;
  logic                lose_lock;

  assign timeout_eff = (timeout == '0) ? TimeoutW'(1) : timeout;
  assign timer_hit   = (timer_q == (timeout_eff - TimeoutW'(1)));
  // A simultaneous ok+err counts as a single error.
  assign frame_any   = frame_ok | frame_err;

  // A frame in TRACK clears the timer, so it takes priority over starvation.
  assign lose_track = en && (state_q == StTrack) && (frame_err || (!frame_ok && timer_hit));
  assign lose_lock  = en && (state_q == StLocked) && (err_trip || (!frame_any && timer_hit));

  rx_frame_window #(
    .WIN     (WIN),
    .ERR_THR (ERR_THR)
  ) u_window (
    .clk_i      (clk),
    .rst_i      (rst),
    .active_i   (en && (state_q == StLocked)),
    .frame_i    (frame_any),
    .err_i      (frame_err),
    .err_trip_o (err_trip)
  );

  assign frsync_ctrl = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      good_q     <= '0;
      thr_lvl    <= '0;
      thr_base_q <= '0;
      resync     <= 1'b0;
      link_up    <= 1'b0;
      n_resync   <= '0;
    end else begin
      resync <= lose_track | lose_lock;
      if ((lose_track || lose_lock) && (n_resync != 16'hFFFF)) begin
        n_resync <= n_resync + 16'd1;
      end

      if (!en) begin
        state_q <= StIdle;
        timer_q <= '0;
        good_q  <= '0;
        link_up <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q    <= StSearch;
            thr_lvl    <= thr_init;
            thr_base_q <= thr_init;
            timer_q    <= '0;
          end
          StSearch: begin
            if (corr_pr_detect) begin
              state_q <= StTrack;
              timer_q <= '0;
              good_q  <= '0;
            end else if (timer_hit) begin
              timer_q <= '0;
              thr_lvl <= thr_step_down(thr_lvl, THR_STEP, THR_MIN);
            end else begin
              timer_q <= timer_q + TimeoutW'(1);
            end
          end
          StTrack: begin
            if (lose_track) begin
              state_q <= StSearch;
              timer_q <= '0;
            end else if (frame_ok) begin
              timer_q <= '0;
              if (good_q == GoodW'(N_LOCK - 1)) begin
                state_q <= StLocked;
                link_up <= 1'b1;
              end else begin
                good_q <= good_q + GoodW'(1);
              end
            end else begin
              timer_q <= timer_q + TimeoutW'(1);
            end
          end
          StLocked: begin
            if (lose_lock) begin
              state_q <= StSearch;
              timer_q <= '0;
              thr_lvl <= thr_base_q;
              link_up <= 1'b0;
            end else if (frame_any) begin
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TimeoutW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Scoreboard bench for rx_link_ctrl: expected output snapshots are queued as stimulus is
// applied and compared after the following clock edge.
module tb_rx_link_ctrl;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_SEARCH = 2'b01;
  localparam logic [1:0] S_TRACK  = 2'b10;
  localparam logic [1:0] S_LOCKED = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] thr_init;
  logic [19:0] timeout;
  logic        corr_pr_detect;
  logic        frame_ok;
  logic        frame_err;
  logic [23:0] thr_lvl;
  logic [1:0]  frsync_ctrl;
  logic        resync;
  logic        link_up;
  logic [15:0] n_resync;

  rx_link_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .thr_init       (thr_init),
    .timeout        (timeout),
    .corr_pr_detect (corr_pr_detect),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .thr_lvl        (thr_lvl),
    .frsync_ctrl    (frsync_ctrl),
    .resync         (resync),
    .link_up        (link_up),
    .n_resync       (n_resync)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic        lu;
    logic [23:0] thr;
    logic        rs;
    logic [15:0] nr;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic lu,
                            input logic [23:0] thr, input logic rs, input logic [15:0] nr);
    exp_t e;
    e.tag = tag; e.st = st; e.lu = lu; e.thr = thr; e.rs = rs; e.nr = nr;
    sb_q.push_back(e);
  endtask

  // Advance one clock and score every snapshot queued for this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "/state"}, 32'(frsync_ctrl), 32'(e.st));
      check_val({e.tag, "/link_up"}, 32'(link_up), 32'(e.lu));
      check_val({e.tag, "/thr_lvl"}, 32'(thr_lvl), 32'(e.thr));
      check_val({e.tag, "/resync"}, 32'(resync), 32'(e.rs));
      check_val({e.tag, "/n_resync"}, 32'(n_resync), 32'(e.nr));
    end
  endtask

  task automatic pulse_frame(input logic ok, input logic err);
    frame_ok  = ok;
    frame_err = err;
    tick();
    frame_ok  = 1'b0;
    frame_err = 1'b0;
  endtask

  task automatic pulse_detect();
    corr_pr_detect = 1'b1;
    tick();
    corr_pr_detect = 1'b0;
  endtask

  logic [23:0] thr_exp;
  logic        is_err;

  initial begin
    rst = 1'b1; en = 1'b0; thr_init = 24'h008000; timeout = 20'd100;
    corr_pr_detect = 1'b0; frame_ok = 1'b0; frame_err = 1'b0;

    expect_out("reset", S_IDLE, 1'b0, 24'h0, 1'b0, 16'd0);
    tick();
    rst = 1'b0;
    en  = 1'b1;
    expect_out("enter_search", S_SEARCH, 1'b0, 24'h008000, 1'b0, 16'd0);
    tick();

    // Threshold stepping every 100 cycles.
    thr_exp = 24'h008000;
    for (int k = 0; k < 3; k++) begin
      repeat (98) tick();
      expect_out("pre_step", S_SEARCH, 1'b0, thr_exp, 1'b0, 16'd0);
      tick();
      thr_exp = thr_exp - 24'h000400;
      expect_out("step", S_SEARCH, 1'b0, thr_exp, 1'b0, 16'd0);
      tick();
    end

    // Detect on the timeout cycle: detect wins, no step.
    repeat (99) tick();
    expect_out("det_at_timeout", S_TRACK, 1'b0, 24'h007400, 1'b0, 16'd0);
    pulse_detect();

    // Four good frames lock the link.
    for (int i = 0; i < 4; i++) begin
      expect_out("lock_seq", (i < 3) ? S_TRACK : S_LOCKED, (i == 3), 24'h007400, 1'b0, 16'd0);
      pulse_frame(1'b1, 1'b0);
      tick();
    end

    // Three errors per 64-frame window, twice: link stays up.
    for (int w = 0; w < 2; w++) begin
      for (int f = 0; f < 64; f++) begin
        is_err = (f == 0) || (f == 10) || (f == 20);
        if (f == 63) expect_out("win_hold", S_LOCKED, 1'b1, 24'h007400, 1'b0, 16'd0);
        pulse_frame(!is_err, is_err);
      end
    end

    // Four errors within one window: lock dropped, threshold reloaded.
    for (int i = 0; i < 15; i++) begin
      is_err = ((i % 6) == 0) || (i == 14);
      if (i == 13) expect_out("burst_pre", S_LOCKED, 1'b1, 24'h007400, 1'b0, 16'd0);
      if (i == 14) expect_out("burst_drop", S_SEARCH, 1'b0, 24'h008000, 1'b1, 16'd1);
      pulse_frame(!is_err, is_err);
    end
    expect_out("resync_width", S_SEARCH, 1'b0, 24'h008000, 1'b0, 16'd1);
    tick();

    // ok+err together in TRACK acts as an error.
    expect_out("track2", S_TRACK, 1'b0, 24'h008000, 1'b0, 16'd1);
    pulse_detect();
    expect_out("ok_err_same", S_SEARCH, 1'b0, 24'h008000, 1'b1, 16'd2);
    pulse_frame(1'b1, 1'b1);

    // Starvation in LOCKED.
    pulse_detect();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_out("relock", S_LOCKED, 1'b1, 24'h008000, 1'b0, 16'd2);
      pulse_frame(1'b1, 1'b0);
    end
    repeat (98) tick();
    expect_out("starve_pre", S_LOCKED, 1'b1, 24'h008000, 1'b0, 16'd2);
    tick();
    expect_out("starve", S_SEARCH, 1'b0, 24'h008000, 1'b1, 16'd3);
    tick();

    // Zero budget acts as one cycle: a step every cycle.
    timeout = 20'd0;
    expect_out("tmo0_a", S_SEARCH, 1'b0, 24'h007C00, 1'b0, 16'd3);
    tick();
    expect_out("tmo0_b", S_SEARCH, 1'b0, 24'h007800, 1'b0, 16'd3);
    tick();
    timeout = 20'd100;

    // Disable in TRACK: IDLE, no resync, threshold held.
    expect_out("track3", S_TRACK, 1'b0, 24'h007800, 1'b0, 16'd3);
    pulse_detect();
    en = 1'b0;
    expect_out("disable", S_IDLE, 1'b0, 24'h007800, 1'b0, 16'd3);
    tick();
    expect_out("idle_hold", S_IDLE, 1'b0, 24'h007800, 1'b0, 16'd3);
    tick();

    // Clamp at the minimum threshold.
    thr_init = 24'h001200;
    en = 1'b1;
    expect_out("reenter", S_SEARCH, 1'b0, 24'h001200, 1'b0, 16'd3);
    tick();
    repeat (99) tick();
    expect_out("clamp", S_SEARCH, 1'b0, 24'h001000, 1'b0, 16'd3);
    tick();
    repeat (99) tick();
    expect_out("clamp_hold", S_SEARCH, 1'b0, 24'h001000, 1'b0, 16'd3);
    tick();

    // Two more resyncs, then lock with n_resync at 5.
    for (int i = 0; i < 2; i++) begin
      pulse_detect();
      expect_out("err_in_track", S_SEARCH, 1'b0, 24'h001000, 1'b1, 16'(4 + i));
      pulse_frame(1'b0, 1'b1);
    end
    pulse_detect();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_out("lock5", S_LOCKED, 1'b1, 24'h001000, 1'b0, 16'd5);
      pulse_frame(1'b1, 1'b0);
    end

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst/state", 32'(frsync_ctrl), 32'(S_IDLE));
    check_val("async_rst/link_up", 32'(link_up), 32'd0);
    check_val("async_rst/thr_lvl", 32'(thr_lvl), 32'd0);
    check_val("async_rst/resync", 32'(resync), 32'd0);
    check_val("async_rst/n_resync", 32'(n_resync), 32'd0);
    tick();
    rst = 1'b0;
    thr_init = 24'h008000;
    expect_out("post_rst", S_SEARCH, 1'b0, 24'h008000, 1'b0, 16'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_link_ctrl.md
# rx_link_ctrl

Acquisition/tracking supervisor for the receive chain. It sequences frame-sync mode and the correlator threshold for the RX physical layer from preamble-detect and CRC verdict pulses. It declares link up/down and forces resynchronisation on timeout or error bursts. It sits beside the PHY/DeFEC pipeline and drives the PHY's `thr_lvl` and `frsync_ctrl` inputs in place of static register values.

## Interface
- `THR_STEP`, 24'h000400: threshold decrement applied on each search timeout.
- `THR_MIN`, 24'h001000: lower saturation bound of `thr_lvl`.
- `N_LOCK`, 4: consecutive good frames required in TRACK to declare lock.
- `WIN`, 64: LOCKED error-window length, in frames.
- `ERR_THR`, 4: errors within one window that drop lock.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  receiver enable; low forces IDLE.
- `thr_init`  in  24  starting correlator threshold, sampled on IDLE→SEARCH.
- `timeout`  in  20  cycle budget for SEARCH and for frame-starvation in TRACK/LOCKED; 0 treated as 1.
- `corr_pr_detect`  in  1  one-cycle preamble-detect pulse from PHY.
- `frame_ok`  in  1  one-cycle CRC-pass pulse.
- `frame_err`  in  1  one-cycle CRC-fail pulse.
- `thr_lvl`  out  24  threshold to PHY.
- `frsync_ctrl`  out  2  00 IDLE, 01 SEARCH, 10 TRACK, 11 LOCKED.
- `resync`  out  1  one-cycle pulse on every return to SEARCH from TRACK/LOCKED.
- `link_up`  out  1  high only in LOCKED.
- `n_resync`  out  16  saturating count of `resync` pulses.

## Operation
- **IDLE:** wait for `en`=1. On that edge: go to SEARCH, load `thr_lvl`←`thr_init`, clear timer.
- **SEARCH:**
  - `corr_pr_detect` → TRACK; clear timer and good-frame count.
  - Timer reaching `timeout` → stay in SEARCH, restart timer, `thr_lvl`←max(`thr_lvl`−THR_STEP, THR_MIN). Subtraction is 25-bit, clamped.
  - Detect and timeout in the same cycle: detect wins.
- **TRACK:**
  - `frame_ok` increments the good count and clears the timer. Count reaching N_LOCK → LOCKED; clear window and error counters.
  - `frame_err` → SEARCH with `resync`.
  - Timer reaching `timeout` → SEARCH with `resync`.
  - `thr_lvl` is held.
- **LOCKED:**
  - Every `frame_ok`/`frame_err` increments the frame counter; `frame_err` also increments the error counter; any frame clears the timer.
  - Error counter reaching ERR_THR → SEARCH with `resync`, `thr_lvl`←`thr_init`.
  - Frame counter reaching WIN → both counters clear in the same cycle.
  - If the error threshold and the window end coincide, the error threshold wins.
  - Timer reaching `timeout` → SEARCH with `resync`, `thr_lvl`←`thr_init`.
- `frame_ok` and `frame_err` in the same cycle: treated as a single `frame_err`.
- `corr_pr_detect` is ignored outside SEARCH.
- Frame pulses are ignored in IDLE and SEARCH.
- `en`=0 in any state → IDLE next cycle with no `resync`; `thr_lvl` holds its last value.

## Timing
- All outputs are registered. A state change, `thr_lvl` update, and `resync` are visible on the cycle after the causing input.
- `resync` is exactly one cycle wide.
- `n_resync` updates in the same cycle as `resync`; it saturates at 16'hFFFF.
- Timer is 20-bit. It counts 1 per cycle from 0 after a clear, and "reaches `timeout`" when the registered value equals `timeout`−1. A 1-cycle budget therefore expires every cycle.
- Reset values: state IDLE, `thr_lvl`=0, `frsync_ctrl`=00, `resync`=0, `link_up`=0, `n_resync`=0, all internal counters 0.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronously); the FSM restarts from IDLE after release.

## Structure
- Shared package `rx_ctrl_pkg`:
  - state enum {IDLE, SEARCH, TRACK, LOCKED}, with encodings equal to the `frsync_ctrl` values;
  - default THR_STEP/THR_MIN constants;
  - the 20-bit timeout width.
- One sub-module, `rx_frame_window`: holds the LOCKED frame/error counters, the window-wrap logic, and the ERR_THR compare.
- The FSM, timer, and threshold arithmetic stay in the top module.

## Test plan
- **Search and lock:** `en`=1, `thr_init`=24'h008000, `corr_pr_detect` at cycle 10, then 4 `frame_ok` → expect `frsync_ctrl` 01→10→11 and `link_up`=1 the cycle after the 4th pulse.
- **Threshold stepping:** `timeout`=100, no detect for 350 cycles → expect `thr_lvl` 008000→007C00→007800→007400 at cycles 100, 200, 300. Repeat with `thr_init`=24'h001200 → expect clamp at 001000.
- **Burst loss:** in LOCKED, 4 `frame_err` spread within 64 frames → expect `resync` pulse, `link_up`=0, `thr_lvl`=`thr_init`, `n_resync`=1. With 3 errors per 64-frame window repeated → link stays up.
- **Simultaneous events:**
  - `frame_ok`+`frame_err` in the same cycle in TRACK → expect SEARCH with `resync`.
  - Detect coincident with timeout in SEARCH → expect TRACK and no threshold step.
- **Starvation and disable:**
  - In LOCKED, no frames for `timeout` cycles → expect `resync`.
  - `en` dropped while in TRACK → expect IDLE with no `resync`.
- **Reset mid-operation:** `rst` pulsed while in LOCKED with `n_resync`=5 → expect all outputs zero immediately; on release with `en`=1 → expect SEARCH again with `thr_lvl`=`thr_init`.
